// File: rtl/nibble_bus_feeder_if.sv
// ---------------------------------------------------------------------------
// nibble_bus_feeder_if
//   Groups the byte-request handshake and the outgoing 4-bit nibble bus of
//   nibble_bus_feeder.
//
//   Signals:
//     in_valid   request present (host -> feeder)
//     in_ready   feeder can accept; transfer when in_valid & in_ready
//     in_target  0=UART, 1=SPI, 2=I2C, 3=reserved (dropped)
//     in_data    payload byte
//     nib_out    nibble to the IC data_in (zero when nib_en is low)
//     nib_en     one-cycle strobe, nibble valid (to the IC data_en)
//
//   Modports:
//     master  host side: drives the request, observes ready and the nibble bus
//     slave   feeder side (nibble_bus_feeder)
// ---------------------------------------------------------------------------
interface nibble_bus_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_target;
  logic [7:0] in_data;
  logic [3:0] nib_out;
  logic       nib_en;

  modport master (
    output in_valid, in_target, in_data,
    input  in_ready, nib_out, nib_en
  );

  modport slave (
    input  in_valid, in_target, in_data,
    output in_ready, nib_out, nib_en
  );
endinterface

// File: rtl/nibble_bus_feeder.sv
// ---------------------------------------------------------------------------
// nibble_bus_feeder
//   Buffers byte-wide transfer requests tagged with a peripheral target in a
//   small FIFO and serializes each one onto the IC's 4-bit nibble bus as a
//   three-nibble frame: header {2'b01, target}, data[7:4], data[3:0].
//   A frame starts only once the target peripheral reports not-busy; after
//   the header is out the frame always runs to completion.
//
//   Parameters:
//     DEPTH  FIFO entries (power of two, >= 2)
//     GAP    idle cycles after every nibble strobe (0..15)
//
//   Ports:
//     clk         rising-edge clock
//     reset_n     asynchronous active-low reset
//     bus         request handshake + nibble bus (slave modport)
//     busy_uart   UART busy flag
//     busy_spi    SPI busy flag
//     busy_i2c    I2C busy flag
//     fifo_count  FIFO occupancy (registered)
//     idle        FIFO empty and sequencer idle (combinational from state)
//     drop_err    one-cycle pulse after a target-3 request is discarded
// ---------------------------------------------------------------------------
module nibble_bus_feeder #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  nibble_bus_feeder_if.slave        bus,
  input  logic                      busy_uart,
  input  logic                      busy_spi,
  input  logic                      busy_i2c,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      idle,
  output logic                      drop_err
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   FULL     = CW'(DEPTH);
  localparam logic            GAP_EN   = (GAP != 0);
  // Gap counter is loaded with GAP-1 so the GAP state lasts exactly GAP cycles.
  localparam logic [3:0]      GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_HDR,
    S_HI,
    S_LO,
    S_GAP
  } state_t;

  state_t          state;
  state_t          state_d;
  state_t          after_gap;

  logic [9:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            accept;
  logic            push;
  logic            pop;

  logic [1:0]      frm_tgt;
  logic [7:0]      frm_data;
  logic [3:0]      gap_cnt;
  logic            busy_sel;

  logic [3:0]      nib_out_d;
  logic            nib_en_d;
  logic [3:0]      nib_out_q;
  logic            nib_en_q;

  // Request side: target 3 completes the handshake but is never stored.
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && (bus.in_target != 2'd3);
  assign pop          = (state == S_IDLE) && (fifo_count != '0);

  assign bus.in_ready = (fifo_count != FULL);
  assign idle         = (fifo_count == '0) && (state == S_IDLE);

  assign bus.nib_out  = nib_out_q;
  assign bus.nib_en   = nib_en_q;

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_target, bus.in_data};
    end
  end

  // FIFO control and drop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_err   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      drop_err <= accept && (bus.in_target == 2'd3);
    end
  end

  // Frame register: captured from the FIFO head when IDLE pops.
  always_ff @(posedge clk) begin
    if (pop) begin
      {frm_tgt, frm_data} <= mem[rd_ptr];
    end
  end

  always_comb begin
    busy_sel = 1'b0;
    case (frm_tgt)
      2'd0:    busy_sel = busy_uart;
      2'd1:    busy_sel = busy_spi;
      2'd2:    busy_sel = busy_i2c;
      default: busy_sel = 1'b0;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (fifo_count != '0) state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!busy_sel)        state_d = S_HDR;
      S_HDR:       state_d = GAP_EN ? S_GAP : S_HI;
      S_HI:        state_d = GAP_EN ? S_GAP : S_LO;
      S_LO:        state_d = GAP_EN ? S_GAP : S_IDLE;
      S_GAP:       if (gap_cnt == '0)    state_d = after_gap;
      default:     state_d = S_IDLE;
    endcase
  end

  // Gap counter and the nibble state to resume after the gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt   <= '0;
      after_gap <= S_IDLE;
    end else begin
      case (state)
        S_HDR: begin
          gap_cnt   <= GAP_LAST;
          after_gap <= S_HI;
        end
        S_HI: begin
          gap_cnt   <= GAP_LAST;
          after_gap <= S_LO;
        end
        S_LO: begin
          gap_cnt   <= GAP_LAST;
          after_gap <= S_IDLE;
        end
        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          gap_cnt <= gap_cnt;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the registered strobe lines up
  // with the cycle the sequencer spends in that nibble state.
  always_comb begin
    nib_en_d  = 1'b0;
    nib_out_d = 4'd0;
    case (state_d)
      S_HDR: begin
        nib_en_d  = 1'b1;
        nib_out_d = {2'b01, frm_tgt};
      end
      S_HI: begin
        nib_en_d  = 1'b1;
        nib_out_d = frm_data[7:4];
      end
      S_LO: begin
        nib_en_d  = 1'b1;
        nib_out_d = frm_data[3:0];
      end
      default: begin
        nib_en_d  = 1'b0;
        nib_out_d = 4'd0;
      end
    endcase
  end

  // Output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nib_en_q  <= 1'b0;
      nib_out_q <= 4'd0;
    end else begin
      nib_en_q  <= nib_en_d;
      nib_out_q <= nib_out_d;
    end
  end

endmodule

// File: tb/tb_nibble_bus_feeder.sv
// ---------------------------------------------------------------------------
// tb_nibble_bus_feeder
//   Two feeders (GAP=1 and GAP=0, DEPTH=4) share clock, reset and busy flags.
//   A reference model turns every accepted request into its expected
//   three-nibble frame; a monitor records every strobe with its cycle number.
// ---------------------------------------------------------------------------
module tb_nibble_bus_feeder;

  localparam int G1 = 1;
  localparam int P1 = 1 + G1;
  localparam int S1 = 2 * P1 + G1 + 3;   // HDR-to-HDR stride, queued frames
  localparam int G0 = 0;
  localparam int P0 = 1 + G0;
  localparam int S0 = 2 * P0 + G0 + 3;

  logic clk = 1'b0;
  logic reset_n;
  logic busy_uart, busy_spi, busy_i2c;
  logic [2:0] cnt1, cnt0;
  logic idle1, idle0, drop1, drop0;

  always #5 clk = ~clk;

  nibble_bus_feeder_if bus1 ();
  nibble_bus_feeder_if bus0 ();

  nibble_bus_feeder #(.DEPTH(4), .GAP(G1)) u_gap1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1),
    .busy_uart(busy_uart), .busy_spi(busy_spi), .busy_i2c(busy_i2c),
    .fifo_count(cnt1), .idle(idle1), .drop_err(drop1)
  );

  nibble_bus_feeder #(.DEPTH(4), .GAP(G0)) u_gap0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0),
    .busy_uart(busy_uart), .busy_spi(busy_spi), .busy_i2c(busy_i2c),
    .fifo_count(cnt0), .idle(idle0), .drop_err(drop0)
  );

  typedef struct packed {
    int         cyc;
    logic [3:0] nib;
  } strobe_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         zero_viol = 0;
  int         drop_cnt1 = 0;
  strobe_t    st1_q[$];
  strobe_t    st0_q[$];
  logic [3:0] exp1_q[$];
  logic [3:0] exp0_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: a strobe seen after edge k is tagged with cycle k.
  always @(negedge clk) begin
    strobe_t s;
    if (bus1.nib_en === 1'b1) begin
      s.cyc = cyc; s.nib = bus1.nib_out; st1_q.push_back(s);
    end else if (bus1.nib_out !== 4'd0) zero_viol++;
    if (bus0.nib_en === 1'b1) begin
      s.cyc = cyc; s.nib = bus0.nib_out; st0_q.push_back(s);
    end else if (bus0.nib_out !== 4'd0) zero_viol++;
    if (drop1 === 1'b1) drop_cnt1++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drives a request, waits for acceptance, and feeds the reference model.
  // Entered and left at 1 time unit after a rising edge.
  task automatic push_req(input bit g0, input logic [1:0] t, input logic [7:0] d,
                          output int hs);
    bit rdy;
    hs = -1;
    if (g0) begin bus0.in_valid = 1'b1; bus0.in_target = t; bus0.in_data = d; end
    else    begin bus1.in_valid = 1'b1; bus1.in_target = t; bus1.in_data = d; end
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      rdy = g0 ? bus0.in_ready : bus1.in_ready;
      if (rdy) begin hs = cyc + 1; break; end
    end
    if (hs < 0) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready got 0 want 1 within 100 cycles");
    end
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    if (hs >= 0 && t != 2'd3) begin
      if (g0) begin exp0_q.push_back({2'b01, t}); exp0_q.push_back(d[7:4]); exp0_q.push_back(d[3:0]); end
      else    begin exp1_q.push_back({2'b01, t}); exp1_q.push_back(d[7:4]); exp1_q.push_back(d[3:0]); end
    end
  endtask

  task automatic wait_idle(input bit g0, input int budget, input string tag);
    bit done = 1'b0;
    for (int w = 0; w < budget && !done; w++) begin
      @(negedge clk);
      done = g0 ? idle0 : idle1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: idle got 0 want 1 within %0d cycles", tag, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    busy_uart = 1'b0; busy_spi = 1'b0; busy_i2c = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_target = 2'd0; bus1.in_data = 8'd0;
    bus0.in_valid = 1'b0; bus0.in_target = 2'd0; bus0.in_data = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (bus1.nib_en !== 1'b0)   begin errors++; $display("FAIL reset_nib_en: got %b want 0", bus1.nib_en); end
    checks++; if (bus1.nib_out !== 4'd0)  begin errors++; $display("FAIL reset_nib_out: got %h want 0", bus1.nib_out); end
    checks++; if (drop1 !== 1'b0)         begin errors++; $display("FAIL reset_drop_err: got %b want 0", drop1); end
    checks++; if (cnt1 !== 3'd0)          begin errors++; $display("FAIL reset_fifo_count: got %0d want 0", cnt1); end
    checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus1.in_ready); end
    checks++; if (idle1 !== 1'b1)         begin errors++; $display("FAIL reset_idle: got %b want 1", idle1); end
    checks++; if (idle0 !== 1'b1 || cnt0 !== 3'd0) begin errors++; $display("FAIL reset_gap0: idle %b count %0d want 1 0", idle0, cnt0); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (idle1 !== 1'b1 || bus1.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset: idle %b ready %b want 1 1", idle1, bus1.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    logic [1:0] t; logic [7:0] d; int hs;
    for (int it = 0; it < 4; it++) begin
      t = (it == 0) ? 2'd1 : 2'($urandom_range(0, 2));
      d = (it == 0) ? 8'hA5 : 8'($urandom);
      push_req(1'b0, t, d, hs);
      checks++; if (cnt1 !== 3'd1) begin errors++; $display("FAIL single_count_push: got %0d want 1", cnt1); end
      wait_idle(1'b0, 50, "single");
      checks++; if (cnt1 !== 3'd0) begin errors++; $display("FAIL single_count_end: got %0d want 0", cnt1); end
      checks++;
      if (st1_q.size() != 3) begin
        errors++; $display("FAIL single_nstrobes: got %0d want 3", st1_q.size());
      end else begin
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (st1_q[k].nib !== exp1_q[k] || st1_q[k].cyc != hs + 2 + k * P1) begin
            errors++;
            $display("FAIL single_strobe%0d: got %h@%0d want %h@%0d", k, st1_q[k].nib, st1_q[k].cyc, exp1_q[k], hs + 2 + k * P1);
          end
        end
      end
      st1_q.delete(); exp1_q.delete();
    end
  endtask

  task automatic test_backpressure();
    int hs[5]; int rel;
    busy_uart = 1'b1;
    for (int i = 0; i < 5; i++) push_req(1'b0, 2'd0, 8'($urandom), hs[i]);
    checks++; if (hs[4] != hs[0] + 4) begin errors++; $display("FAIL bp_accept_span: got %0d want 4", hs[4] - hs[0]); end
    checks++; if (cnt1 !== 3'd4)        begin errors++; $display("FAIL bp_count_full: got %0d want 4", cnt1); end
    checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", bus1.in_ready); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (st1_q.size() != 0) begin errors++; $display("FAIL bp_held: got %0d strobes want 0", st1_q.size()); end
    busy_uart = 1'b0;
    rel = cyc;
    wait_idle(1'b0, 200, "bp");
    checks++;
    if (st1_q.size() != 15) begin
      errors++; $display("FAIL bp_nstrobes: got %0d want 15", st1_q.size());
    end else begin
      for (int k = 0; k < 15; k++) begin
        checks++;
        if (st1_q[k].nib !== exp1_q[k] || st1_q[k].cyc != rel + 1 + (k / 3) * S1 + (k % 3) * P1) begin
          errors++;
          $display("FAIL bp_strobe%0d: got %h@%0d want %h@%0d", k, st1_q[k].nib, st1_q[k].cyc, exp1_q[k], rel + 1 + (k / 3) * S1 + (k % 3) * P1);
        end
      end
    end
    st1_q.delete(); exp1_q.delete();
  endtask

  task automatic test_drop();
    int hs;
    push_req(1'b0, 2'd3, 8'hFF, hs);
    checks++; if (drop1 !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b want 1", drop1); end
    checks++; if (cnt1 !== 3'd0)  begin errors++; $display("FAIL drop_count: got %0d want 0", cnt1); end
    @(posedge clk); #1;
    checks++; if (drop1 !== 1'b0) begin errors++; $display("FAIL drop_one_cycle: got %b want 0", drop1); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (st1_q.size() != 0 || idle1 !== 1'b1) begin errors++; $display("FAIL drop_quiet: strobes %0d idle %b want 0 1", st1_q.size(), idle1); end
  endtask

  task automatic test_busy();
    int hs; int rel; bit seen = 1'b0;
    push_req(1'b0, 2'd2, 8'h3C, hs);
    for (int w = 0; w < 20 && !seen; w++) begin @(negedge clk); seen = (st1_q.size() != 0); end
    busy_i2c = 1'b1;
    wait_idle(1'b0, 50, "busy_mid");
    busy_i2c = 1'b0;
    checks++;
    if (st1_q.size() != 3) begin
      errors++; $display("FAIL busy_mid_nstrobes: got %0d want 3", st1_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (st1_q[k].nib !== exp1_q[k] || st1_q[k].cyc != hs + 2 + k * P1) begin
          errors++;
          $display("FAIL busy_mid_strobe%0d: got %h@%0d want %h@%0d", k, st1_q[k].nib, st1_q[k].cyc, exp1_q[k], hs + 2 + k * P1);
        end
      end
    end
    st1_q.delete(); exp1_q.delete();
    busy_spi = 1'b1;
    push_req(1'b0, 2'd1, 8'($urandom), hs);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (st1_q.size() != 0) begin errors++; $display("FAIL busy_wait_held: got %0d strobes want 0", st1_q.size()); end
    busy_spi = 1'b0;
    rel = cyc;
    wait_idle(1'b0, 50, "busy_wait");
    checks++;
    if (st1_q.size() != 3) begin
      errors++; $display("FAIL busy_wait_nstrobes: got %0d want 3", st1_q.size());
    end else begin
      checks++;
      if (st1_q[0].nib !== exp1_q[0] || st1_q[0].cyc != rel + 1) begin
        errors++; $display("FAIL busy_wait_hdr: got %h@%0d want %h@%0d", st1_q[0].nib, st1_q[0].cyc, exp1_q[0], rel + 1);
      end
    end
    st1_q.delete(); exp1_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [1:0] t; int hs; int first = -1; int ndrop = 0; int n;
    drop_cnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      t = 2'($urandom_range(0, 3));
      if (i == 0) t = 2'($urandom_range(0, 2));
      push_req(1'b0, t, 8'($urandom), hs);
      if (t == 2'd3) ndrop++;
      if (first < 0 && t != 2'd3) first = hs;
    end
    wait_idle(1'b0, 300, "b2b");
    n = exp1_q.size();
    checks++; if (drop_cnt1 != ndrop) begin errors++; $display("FAIL b2b_drops: got %0d want %0d", drop_cnt1, ndrop); end
    checks++;
    if (st1_q.size() != n) begin
      errors++; $display("FAIL b2b_nstrobes: got %0d want %0d", st1_q.size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        checks++;
        if (st1_q[k].nib !== exp1_q[k] || st1_q[k].cyc != first + 2 + (k / 3) * S1 + (k % 3) * P1) begin
          errors++;
          $display("FAIL b2b_strobe%0d: got %h@%0d want %h@%0d", k, st1_q[k].nib, st1_q[k].cyc, exp1_q[k], first + 2 + (k / 3) * S1 + (k % 3) * P1);
        end
      end
    end
    st1_q.delete(); exp1_q.delete();
  endtask

  task automatic test_reset_midframe();
    int hs; bit seen = 1'b0;
    for (int i = 0; i < 3; i++) push_req(1'b0, 2'd0, 8'($urandom), hs);
    for (int w = 0; w < 30 && !seen; w++) begin @(negedge clk); seen = (st1_q.size() >= 2); end
    checks++; if (!seen || st1_q[1].nib !== exp1_q[1]) begin errors++; $display("FAIL rst_mid_hi: got %0d strobes want HI nibble %h", st1_q.size(), exp1_q[1]); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus1.nib_en !== 1'b0 || bus1.nib_out !== 4'd0) begin errors++; $display("FAIL rst_mid_async: en %b out %h want 0 0", bus1.nib_en, bus1.nib_out); end
    checks++; if (cnt1 !== 3'd0 || idle1 !== 1'b1) begin errors++; $display("FAIL rst_mid_state: count %0d idle %b want 0 1", cnt1, idle1); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (st1_q.size() != 2) begin errors++; $display("FAIL rst_mid_quiet: got %0d strobes want 2", st1_q.size()); end
    checks++; if (cnt1 !== 3'd0 || idle1 !== 1'b1) begin errors++; $display("FAIL rst_mid_after: count %0d idle %b want 0 1", cnt1, idle1); end
    st1_q.delete(); exp1_q.delete();
  endtask

  task automatic test_gap0();
    int hs_a; int hs_b;
    push_req(1'b1, 2'd0, 8'h12, hs_a);
    push_req(1'b1, 2'd0, 8'h34, hs_b);
    checks++; if (hs_b != hs_a + 1) begin errors++; $display("FAIL gap0_accept: got %0d want %0d", hs_b, hs_a + 1); end
    wait_idle(1'b1, 50, "gap0");
    checks++;
    if (st0_q.size() != 6) begin
      errors++; $display("FAIL gap0_nstrobes: got %0d want 6", st0_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (st0_q[k].nib !== exp0_q[k] || st0_q[k].cyc != hs_a + 2 + (k / 3) * S0 + (k % 3) * P0) begin
          errors++;
          $display("FAIL gap0_strobe%0d: got %h@%0d want %h@%0d", k, st0_q[k].nib, st0_q[k].cyc, exp0_q[k], hs_a + 2 + (k / 3) * S0 + (k % 3) * P0);
        end
      end
    end
    st0_q.delete(); exp0_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_drop();
    test_busy();
    test_back_to_back();
    test_reset_midframe();
    test_gap0();
    checks++; if (zero_viol != 0) begin errors++; $display("FAIL nib_out_zero: got %0d nonzero idle cycles want 0", zero_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
